// File: rtl/md_sched_pkg.sv
// ----------------------------------------------------------------------------
// md_sched_pkg
// Shared definitions for the multiply/divide issue scoreboard:
//   REG_W        register index width
//   MUL_LAT_DEF  default issue-to-writeback latency of a multiply
//   DIV_LAT_DEF  default issue-to-writeback latency of a divide
//   CNT_W        width of a slot's remaining-latency counter
//   slot_t       one in-flight op: valid, destination, op kind, cycles left
// ----------------------------------------------------------------------------
package md_sched_pkg;

  localparam int REG_W       = 5;
  localparam int MUL_LAT_DEF = 16;
  localparam int DIV_LAT_DEF = 16;

  function automatic int max_lat(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_LAT = max_lat(MUL_LAT_DEF, DIV_LAT_DEF);

  // The counter holds LAT-1 down to 0, so it never needs to represent LAT.
  localparam int CNT_W = $clog2(MAX_LAT);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             is_div;
    logic [CNT_W-1:0] count;
  } slot_t;

endpackage

// File: rtl/md_wb_reservation.sv
// ----------------------------------------------------------------------------
// md_wb_reservation
// Tracks which future cycles already own the md side of the regfile write
// port. Bit i of the vector means "an md result writes back i cycles from
// now". The vector shifts down every cycle; a set for latency L lands in bit
// L-1 after the shift, which is exactly L cycles after the issuing cycle.
// Ports:
//   clock, reset  rising-edge clock, synchronous active-high clear
//   set_en        reserve the slot for an op accepted this cycle
//   lat           latency of the op being queried / reserved
//   busy          the writeback cycle for 'lat' is already taken
// ----------------------------------------------------------------------------
module md_wb_reservation #(
  parameter int RES_W = 16,
  parameter int LAT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             set_en,
  input  logic [LAT_W-1:0] lat,
  output logic             busy
);

  logic [RES_W-1:0] res_q;
  logic [RES_W-1:0] res_d;

  // A latency equal to RES_W targets a cycle beyond the window, which no
  // earlier op can have claimed, so it is always free.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < RES_W; i++) begin
      if (lat == LAT_W'(i)) busy = res_q[i];
    end
  end

  always_comb begin
    res_d = {1'b0, res_q[RES_W-1:1]};
    for (int i = 0; i < RES_W; i++) begin
      if (set_en && (lat == LAT_W'(i + 1))) res_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) res_q <= '0;
    else       res_q <= res_d;
  end

endmodule

// File: rtl/md_issue_scoreboard.sv
// ----------------------------------------------------------------------------
// md_issue_scoreboard
// Issue/hazard/writeback scheduler for the multiply/divide unit beside the
// 5-stage core. Tracks up to SLOTS in-flight ops, stalls D on RAW/WAW against
// their destinations, and shares the single regfile write port with main W.
// Optional feature macro: MD_EXC_STATUS_EN (md exception -> status_we).
// Ports:
//   clock, reset                      clock, synchronous active-high clear
//   issue_valid/is_div/rd, flush      X-stage md issue and redirect
//   issue_ready                       issue accepted this cycle
//   d_rs/d_rt/d_uses_rs/d_uses_rt     D-stage source operands
//   d_rd/d_writes                     D-stage destination
//   hazard_stall                      hold F/D, bubble into X
//   w_valid / w_hold                  main W write request / retry
//   md_exc                            md exception flag on completion
//   wb_en/wb_sel_md/wb_rd             regfile write port control
//   status_we                         status register write on md exception
// ----------------------------------------------------------------------------
module md_issue_scoreboard
  import md_sched_pkg::*;
#(
  parameter int SLOTS   = 4,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic             issue_is_div,
  input  logic [REG_W-1:0] issue_rd,
  input  logic             flush,
  output logic             issue_ready,
  input  logic [REG_W-1:0] d_rs,
  input  logic [REG_W-1:0] d_rt,
  input  logic             d_uses_rs,
  input  logic             d_uses_rt,
  input  logic [REG_W-1:0] d_rd,
  input  logic             d_writes,
  output logic             hazard_stall,
  input  logic             w_valid,
  output logic             w_hold,
  input  logic             md_exc,
  output logic             wb_en,
  output logic             wb_sel_md,
  output logic [REG_W-1:0] wb_rd,
  output logic             status_we
);

  localparam int RES_W = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int LAT_W = $clog2(RES_W + 1);
  localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  slot_t            slots_q [SLOTS];
  slot_t            slots_d [SLOTS];
  logic [SLOTS-1:0] slot_done;
  logic             cmp_any;
  logic [REG_W-1:0] cmp_rd;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic [LAT_W-1:0] issue_lat;
  logic             res_busy;
  logic             accept;
  logic             rs_hit;
  logic             rt_hit;
  logic             rd_hit;
  logic             md_wb;
  logic [SLOTS-1:0] unused_is_div;

  // rd==0 never produces a write, so it can never be a hazard source.
  function automatic logic pend_match(input logic             pend,
                                      input logic [REG_W-1:0] pend_rd,
                                      input logic [REG_W-1:0] src);
    return pend && (pend_rd != '0) && (pend_rd == src);
  endfunction

  assign issue_lat = issue_is_div ? LAT_W'(DIV_LAT) : LAT_W'(MUL_LAT);

  // Completion scan and free-slot search. The reservation vector guarantees
  // at most one slot reaches count 0 in any cycle. A completing slot counts
  // as free so it can be re-allocated in the same cycle.
  always_comb begin
    cmp_any       = 1'b0;
    cmp_rd        = '0;
    free_found    = 1'b0;
    free_idx      = '0;
    slot_done     = '0;
    unused_is_div = '0;
    for (int i = 0; i < SLOTS; i++) begin
      unused_is_div[i] = slots_q[i].is_div;
      slot_done[i]     = slots_q[i].valid && (slots_q[i].count == '0);
      if (slot_done[i]) begin
        cmp_any = 1'b1;
        cmp_rd  = slots_q[i].rd;
      end
      if (!free_found && (!slots_q[i].valid || slot_done[i])) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  md_wb_reservation #(
    .RES_W (RES_W),
    .LAT_W (LAT_W)
  ) u_res (
    .clock  (clock),
    .reset  (reset),
    .set_en (accept),
    .lat    (issue_lat),
    .busy   (res_busy)
  );

  assign accept      = issue_valid && !flush && free_found && !res_busy;
  assign issue_ready = accept;

  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      slots_d[i] = slots_q[i];
      if (slot_done[i])          slots_d[i].valid = 1'b0;
      else if (slots_q[i].valid) slots_d[i].count = slots_q[i].count - 1'b1;
      if (accept && (free_idx == IDX_W'(i))) begin
        slots_d[i].valid  = 1'b1;
        slots_d[i].rd     = issue_rd;
        slots_d[i].is_div = issue_is_div;
        slots_d[i].count  = CNT_W'(issue_lat - 1'b1);
      end
    end
  end

  // Completing slots are excluded: the regfile writes on the falling edge,
  // so D already reads the fresh value this cycle.
  always_comb begin
    rs_hit = pend_match(accept, issue_rd, d_rs);
    rt_hit = pend_match(accept, issue_rd, d_rt);
    rd_hit = pend_match(accept, issue_rd, d_rd);
    for (int i = 0; i < SLOTS; i++) begin
      rs_hit |= pend_match(slots_q[i].valid && !slot_done[i], slots_q[i].rd, d_rs);
      rt_hit |= pend_match(slots_q[i].valid && !slot_done[i], slots_q[i].rd, d_rt);
      rd_hit |= pend_match(slots_q[i].valid && !slot_done[i], slots_q[i].rd, d_rd);
    end
  end

  assign hazard_stall = (d_uses_rs && (d_rs != '0) && rs_hit) ||
                        (d_uses_rt && (d_rt != '0) && rt_hit) ||
                        (d_writes  && (d_rd != '0) && rd_hit);

  // md completions own the port; main W is held and retries next cycle.
  // When main W writes, its rd comes from the external mux, so wb_rd is 0.
  assign md_wb     = cmp_any && (cmp_rd != '0);
  assign wb_en     = md_wb || w_valid;
  assign wb_sel_md = md_wb;
  assign wb_rd     = md_wb ? cmp_rd : '0;
  assign w_hold    = md_wb && w_valid;

`ifdef MD_EXC_STATUS_EN
  assign status_we = cmp_any && md_exc;
`else
  logic unused_md_exc;
  assign unused_md_exc = md_exc;
  assign status_we     = 1'b0;
`endif

  always_ff @(posedge clock) begin
    for (int i = 0; i < SLOTS; i++) begin
      if (reset) slots_q[i] <= '0;
      else       slots_q[i] <= slots_d[i];
    end
  end

endmodule

// File: tb/tb_md_issue_scoreboard.sv
module tb_md_issue_scoreboard;
  import md_sched_pkg::*;

`ifdef MD_EXC_STATUS_EN
  localparam logic EXC_EN = 1'b1;
`else
  localparam logic EXC_EN = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic             issue_valid;
  logic             issue_is_div;
  logic [REG_W-1:0] issue_rd;
  logic             flush;
  logic             issue_ready;
  logic [REG_W-1:0] d_rs;
  logic [REG_W-1:0] d_rt;
  logic             d_uses_rs;
  logic             d_uses_rt;
  logic [REG_W-1:0] d_rd;
  logic             d_writes;
  logic             hazard_stall;
  logic             w_valid;
  logic             w_hold;
  logic             md_exc;
  logic             wb_en;
  logic             wb_sel_md;
  logic [REG_W-1:0] wb_rd;
  logic             status_we;

  int n_cmp = 0;
  int n_err = 0;

  md_issue_scoreboard dut (
    .clock        (clock),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_is_div (issue_is_div),
    .issue_rd     (issue_rd),
    .flush        (flush),
    .issue_ready  (issue_ready),
    .d_rs         (d_rs),
    .d_rt         (d_rt),
    .d_uses_rs    (d_uses_rs),
    .d_uses_rt    (d_uses_rt),
    .d_rd         (d_rd),
    .d_writes     (d_writes),
    .hazard_stall (hazard_stall),
    .w_valid      (w_valid),
    .w_hold       (w_hold),
    .md_exc       (md_exc),
    .wb_en        (wb_en),
    .wb_sel_md    (wb_sel_md),
    .wb_rd        (wb_rd),
    .status_we    (status_we)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    issue_valid  = 1'b0;
    issue_is_div = 1'b0;
    issue_rd     = '0;
    flush        = 1'b0;
    d_rs         = '0;
    d_rt         = '0;
    d_uses_rs    = 1'b0;
    d_uses_rt    = 1'b0;
    d_rd         = '0;
    d_writes     = 1'b0;
    w_valid      = 1'b0;
    md_exc       = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++;
    if ({issue_ready, hazard_stall, w_hold, wb_en, wb_sel_md, status_we} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {issue_ready, hazard_stall, w_hold, wb_en, wb_sel_md, status_we});
    end
    n_cmp++;
    if (wb_rd !== 5'd0) begin
      n_err++;
      $display("FAIL reset_wb_rd: got %0d want 0", wb_rd);
    end
  endtask

  // mult rd=5 at cycle 0: writeback exactly at cycle 16, RAW stall 1..15
  task automatic test_mul_latency();
    logic exp_stall;
    logic exp_wb;
    do_reset();
    issue_valid = 1'b1;
    issue_rd    = 5'd5;
    #1;
    n_cmp++;
    if (issue_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mul_issue_ready: got %b want 1", issue_ready);
    end
    tick();
    issue_valid = 1'b0;
    issue_rd    = '0;
    d_rs        = 5'd5;
    d_uses_rs   = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      #1;
      exp_stall = (k < 16);
      exp_wb    = (k == 16);
      n_cmp++;
      if (hazard_stall !== exp_stall) begin
        n_err++;
        $display("FAIL raw_stall_c%0d: got %b want %b", k, hazard_stall, exp_stall);
      end
      n_cmp++;
      if ({wb_en, wb_sel_md} !== {exp_wb, exp_wb}) begin
        n_err++;
        $display("FAIL mul_wb_c%0d: got en/sel %b%b want %b%b", k, wb_en, wb_sel_md, exp_wb, exp_wb);
      end
      n_cmp++;
      if (wb_rd !== (exp_wb ? 5'd5 : 5'd0)) begin
        n_err++;
        $display("FAIL mul_wb_rd_c%0d: got %0d want %0d", k, wb_rd, exp_wb ? 5 : 0);
      end
      tick();
    end
  endtask

  // Four ops fill the table; the re-presented fifth is accepted into the
  // slot freed by the cycle-16 completion.
  task automatic test_slots_full();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      issue_valid = 1'b1;
      issue_rd    = 5'(c + 1);
      #1;
      n_cmp++;
      if (issue_ready !== 1'b1) begin
        n_err++;
        $display("FAIL fill_ready_c%0d: got %b want 1", c, issue_ready);
      end
      tick();
    end
    issue_rd = 5'd6;
    for (int c = 4; c < 16; c++) begin
      #1;
      n_cmp++;
      if (issue_ready !== 1'b0) begin
        n_err++;
        $display("FAIL full_reject_c%0d: got %b want 0", c, issue_ready);
      end
      tick();
    end
    #1;
    n_cmp++;
    if (issue_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reuse_ready_c16: got %b want 1", issue_ready);
    end
    n_cmp++;
    if ({wb_en, wb_sel_md, wb_rd} !== {1'b1, 1'b1, 5'd1}) begin
      n_err++;
      $display("FAIL reuse_wb_c16: got en=%b sel=%b rd=%0d want 1 1 1", wb_en, wb_sel_md, wb_rd);
    end
    tick();
    issue_valid = 1'b0;
    issue_rd    = '0;
    #1;
    n_cmp++;
    if ({wb_en, wb_rd} !== {1'b1, 5'd2}) begin
      n_err++;
      $display("FAIL slot1_wb_c17: got en=%b rd=%0d want 1 2", wb_en, wb_rd);
    end
    tick();
    for (int c = 18; c < 32; c++) tick();
    #1;
    n_cmp++;
    if ({wb_en, wb_sel_md, wb_rd} !== {1'b1, 1'b1, 5'd6}) begin
      n_err++;
      $display("FAIL reused_wb_c32: got en=%b sel=%b rd=%0d want 1 1 6", wb_en, wb_sel_md, wb_rd);
    end
  endtask

  task automatic test_hazard_sources();
    do_reset();
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    d_rd        = 5'd9;
    d_writes    = 1'b1;
    #1;
    n_cmp++;
    if (hazard_stall !== 1'b1) begin
      n_err++;
      $display("FAIL waw_same_cycle: got %b want 1", hazard_stall);
    end
    d_writes = 1'b0;
    #1;
    n_cmp++;
    if (hazard_stall !== 1'b0) begin
      n_err++;
      $display("FAIL no_write_no_stall: got %b want 0", hazard_stall);
    end
    d_rt      = 5'd9;
    d_uses_rt = 1'b1;
    #1;
    n_cmp++;
    if (hazard_stall !== 1'b1) begin
      n_err++;
      $display("FAIL raw_rt: got %b want 1", hazard_stall);
    end
    d_uses_rt = 1'b0;
    #1;
    n_cmp++;
    if (hazard_stall !== 1'b0) begin
      n_err++;
      $display("FAIL rt_unused: got %b want 0", hazard_stall);
    end
    tick();
    issue_valid = 1'b0;
    issue_rd    = '0;
    d_writes    = 1'b1;
    for (int c = 1; c < 15; c++) tick();
    #1;
    n_cmp++;
    if (hazard_stall !== 1'b1) begin
      n_err++;
      $display("FAIL waw_pending_c15: got %b want 1", hazard_stall);
    end
    tick();
    #1;
    n_cmp++;
    if ({hazard_stall, wb_en} !== 2'b01) begin
      n_err++;
      $display("FAIL waw_completing_c16: got stall=%b en=%b want 0 1", hazard_stall, wb_en);
    end
  endtask

  // mult rd=7 at 0, div rd=0 at 2; main W requests at 16 and 17.
  task automatic test_wb_arbitration();
    do_reset();
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    tick();
    issue_valid = 1'b0;
    issue_rd    = '0;
    tick();
    issue_valid  = 1'b1;
    issue_is_div = 1'b1;
    issue_rd     = 5'd0;
    d_rs         = 5'd0;
    d_uses_rs    = 1'b1;
    #1;
    n_cmp++;
    if ({issue_ready, hazard_stall} !== 2'b10) begin
      n_err++;
      $display("FAIL rd0_issue: got ready=%b stall=%b want 1 0", issue_ready, hazard_stall);
    end
    tick();
    clear_inputs();
    for (int c = 3; c < 16; c++) tick();
    w_valid = 1'b1;
    #1;
    n_cmp++;
    if ({wb_en, wb_sel_md, w_hold, wb_rd} !== {3'b111, 5'd7}) begin
      n_err++;
      $display("FAIL arb_md_wins_c16: got en=%b sel=%b hold=%b rd=%0d want 1 1 1 7",
               wb_en, wb_sel_md, w_hold, wb_rd);
    end
    tick();
    #1;
    n_cmp++;
    if ({wb_en, wb_sel_md, w_hold, wb_rd} !== {3'b100, 5'd0}) begin
      n_err++;
      $display("FAIL arb_main_retry_c17: got en=%b sel=%b hold=%b rd=%0d want 1 0 0 0",
               wb_en, wb_sel_md, w_hold, wb_rd);
    end
    tick();
    w_valid = 1'b0;
    md_exc  = 1'b1;
    #1;
    n_cmp++;
    if (wb_en !== 1'b0) begin
      n_err++;
      $display("FAIL rd0_no_wb_c18: got %b want 0", wb_en);
    end
    n_cmp++;
    if (status_we !== EXC_EN) begin
      n_err++;
      $display("FAIL exc_status_c18: got %b want %b", status_we, EXC_EN);
    end
    tick();
    #1;
    n_cmp++;
    if (status_we !== 1'b0) begin
      n_err++;
      $display("FAIL exc_one_cycle_c19: got %b want 0", status_we);
    end
    md_exc = 1'b0;
  endtask

  task automatic test_flush();
    logic seen;
    do_reset();
    issue_valid = 1'b1;
    flush       = 1'b1;
    issue_rd    = 5'd10;
    #1;
    n_cmp++;
    if (issue_ready !== 1'b0) begin
      n_err++;
      $display("FAIL flush_ready: got %b want 0", issue_ready);
    end
    tick();
    clear_inputs();
    d_rs      = 5'd10;
    d_uses_rs = 1'b1;
    #1;
    n_cmp++;
    if (hazard_stall !== 1'b0) begin
      n_err++;
      $display("FAIL flush_no_stall: got %b want 0", hazard_stall);
    end
    seen = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      if (wb_en) seen = 1'b1;
      tick();
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL flush_no_wb: got wb_en seen=%b want 0", seen);
    end
  endtask

  task automatic test_reset_midflight();
    logic seen;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      issue_valid = 1'b1;
      issue_rd    = 5'(11 + c);
      tick();
    end
    clear_inputs();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    d_rs      = 5'd11;
    d_uses_rs = 1'b1;
    #1;
    n_cmp++;
    if (hazard_stall !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_stall: got %b want 0", hazard_stall);
    end
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (wb_en) seen = 1'b1;
      tick();
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_no_wb: got wb_en seen=%b want 0", seen);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mul_latency();
    test_slots_full();
    test_hazard_sources();
    test_wb_arbitration();
    test_flush();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/md_issue_scoreboard.md
Name: md_issue_scoreboard

Overview:
- Scheduler for the 16-stage multiply/divide pipeline that sits beside the 5-stage core.
- Accepts mult/div issue from the X stage and tracks each in-flight op's destination register and remaining latency.
- Stalls D-stage instructions on RAW/WAW hazards against pending results.
- Arbitrates the single regfile write port between md completions and the main pipeline's W stage, and raises the status-register write on md exceptions.

Parameters:
- SLOTS, 4, max outstanding mult/div ops.
- MUL_LAT, 16, issue-to-writeback cycles for mult.
- DIV_LAT, 16, issue-to-writeback cycles for div.
- REG_W, 5, register index width.

Ports:
- clock  in  1  core clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all state
- issue_valid  in  1  mult/div in X this cycle
- issue_is_div  in  1  1=div, 0=mult
- issue_rd  in  REG_W  destination register
- flush  in  1  X-stage branch/jump redirect; same-cycle issue is dropped
- issue_ready  out  1  issue accepted this cycle
- d_rs, d_rt  in  REG_W  D-stage source regs
- d_uses_rs, d_uses_rt  in  1  source-read qualifiers
- d_rd  in  REG_W  D-stage destination
- d_writes  in  1  D instruction writes regfile
- hazard_stall  out  1  hold F/D, bubble into X
- w_valid  in  1  main-pipe W wants regfile write
- w_hold  out  1  hold M/W latches this cycle
- md_exc  in  1  exception flag from md datapath, valid on completion cycle
- wb_en  out  1  regfile write enable
- wb_sel_md  out  1  1=md result drives write data, 0=main W
- wb_rd  out  REG_W  write register
- status_we  out  1  write status register from md exception

Behaviour:
- Reset: all slots invalid; reservation vector zero; every output 0 on the cycle after reset is sampled high. Reset mid-operation discards every in-flight result; no wb_en for them.
- Slot table: valid, rd, is_div, count per slot. Issue allocates the lowest-index free slot with count = LAT-1; count decrements each cycle; the slot completes when count==0 and frees the same cycle.
- Latency: op accepted at cycle t asserts wb_en/wb_sel_md at cycle t+LAT exactly.
- Writeback reservation: a LAT-bit vector, one bit per future cycle, shifted each cycle. Issue sets bit LAT-1.
- issue_ready = ~flush & free slot exists & target reservation bit clear. With MUL_LAT==DIV_LAT a collision never occurs; unequal latencies can reject an issue.
- Rejected issue: core holds X and re-presents the op; the block stores nothing.
- issue_valid with flush: ignored, issue_ready=0.
- issue_rd==0: a slot and reservation are still used for exception reporting; wb_en stays 0 and no hazard matching occurs.
- Hazards:
  - hazard_stall = RAW | WAW.
  - RAW: (d_uses_rs & d_rs!=0 & d_rs matches a pending rd) or the same for rt.
  - WAW: d_writes & d_rd!=0 & d_rd matches a pending rd.
  - "Pending" means valid slots not completing this cycle, plus the accepted issue this cycle.
  - A slot completing this cycle does not stall; the regfile writes on the falling edge, so D reads the new value.
- Arbitration: on a md completion with rd!=0, wb_en=1, wb_sel_md=1, wb_rd=slot rd. If w_valid is also high, w_hold=1 and main W retries next cycle. Otherwise wb_en=w_valid, wb_sel_md=0, wb_rd from main pipe (external mux; this block passes w_valid through).
- Simultaneous completion and issue to the same freed slot index: the free is seen before allocation, so the slot is reusable the same cycle.

Optional Feature:
- MD_EXC_STATUS_EN defined: status_we pulses for one cycle on any md completion with md_exc=1 (rd==0 included); wb_en remains per the rules above.
- Undefined: md_exc ignored, status_we tied 0, exception logic removed.

Decomposition:
- Package md_sched_pkg: REG_W, MUL_LAT/DIV_LAT defaults, slot struct typedef (valid, rd, is_div, count), and a count-width constant derived from max latency.
- One sub-module, md_wb_reservation: the shifting reservation vector with set/query/advance.
- Slot table and hazard compare stay in the top level.

Test Plan:
- Issue mult rd=5 at cycle 10, no other traffic -> issue_ready=1; wb_en=1, wb_sel_md=1, wb_rd=5 at cycle 26 only.
- After that issue, D reads rs=5 with d_uses_rs=1 at cycles 11..25 -> hazard_stall=1 through cycle 25, 0 at cycle 26.
- Fill 4 slots on cycles 0..3, issue at cycle 4 -> issue_ready=0. At cycle 16 slot0 completes and a same-cycle issue is accepted into slot 0.
- Md completion rd=7 with w_valid=1 at cycle 26 -> w_hold=1, wb_rd=7; cycle 27 -> wb_sel_md=0, w_hold=0.
- Issue with flush=1 -> issue_ready=0, no writeback 16 cycles later. Reset at cycle 20 with 3 ops in flight -> no wb_en afterwards.
- MD_EXC_STATUS_EN: div rd=0 completes with md_exc=1 -> status_we=1 for one cycle, wb_en=0. Without the macro -> status_we stays 0.
